// File: rtl/mmm_modexp_ctrl_if.sv
// rtl/mmm_modexp_ctrl_if.sv - operand/result bus between the modexp sequencer and the Montgomery multiplier
interface mmm_modexp_ctrl_if;
  logic [63:0] mm_x;
  logic [63:0] mm_y;
  logic [63:0] mm_m;
  logic [31:0] mm_n;
  logic [63:0] mm_z;

  modport master (
    output mm_x,
    output mm_y,
    output mm_m,
    output mm_n,
    input  mm_z
  );

  modport slave (
    input  mm_x,
    input  mm_y,
    input  mm_m,
    input  mm_n,
    output mm_z
  );
endinterface

// File: rtl/mmm_modexp_ctrl.sv
// rtl/mmm_modexp_ctrl.sv - left-to-right square-and-multiply sequencer driving a combinational Montgomery multiplier
module mmm_modexp_ctrl #(
  parameter int MM_WAIT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [63:0]              base,
  input  logic [63:0]              exponent,
  input  logic [6:0]               e_len,
  input  logic [63:0]              modulus,
  input  logic [31:0]              n_bits,
  input  logic [63:0]              r2,
  output logic                     busy,
  output logic                     done,
  output logic [63:0]              result,
  mmm_modexp_ctrl_if.master        mm
);

  localparam int CW = (MM_WAIT < 1) ? 1 : $clog2(MM_WAIT + 1);
  localparam logic [CW-1:0] WAIT_C = CW'(MM_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_X,
    S_PRE_A,
    S_SQR,
    S_MUL,
    S_POST,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [6:0]    idx;
  logic [63:0]   exp_q;
  logic [63:0]   r2_q;
  logic [63:0]   xb;
  logic [63:0]   acc;

  logic          in_op;
  logic          op_done;
  logic          load;
  logic          dec;
  logic [5:0]    bit_idx;
  logic          cur_bit;
  logic [63:0]   x_d;
  logic [63:0]   y_d;

  assign in_op   = (state != S_IDLE) && (state != S_DONE);
  assign op_done = in_op && (cnt == WAIT_C);
  // idx counts exponent bits still to process, so the current bit sits at idx-1
  assign bit_idx = 6'(idx - 7'd1);
  assign cur_bit = exp_q[bit_idx];
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    dec     = 1'b0;
    x_d     = 64'd0;
    y_d     = 64'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRE_X;
          load    = 1'b1;
          x_d     = base;
          y_d     = r2;
        end
      end
      S_PRE_X: begin
        if (op_done) begin
          state_d = S_PRE_A;
          load    = 1'b1;
          x_d     = 64'd1;
          y_d     = r2_q;
        end
      end
      S_PRE_A: begin
        if (op_done) begin
          load = 1'b1;
          x_d  = mm.mm_z;
          if (idx == 7'd0) begin
            state_d = S_POST;
            y_d     = 64'd1;
          end else begin
            state_d = S_SQR;
            y_d     = mm.mm_z;
          end
        end
      end
      S_SQR: begin
        if (op_done) begin
          load = 1'b1;
          x_d  = mm.mm_z;
          if (cur_bit) begin
            state_d = S_MUL;
            y_d     = xb;
          end else begin
            dec = 1'b1;
            if (idx == 7'd1) begin
              state_d = S_POST;
              y_d     = 64'd1;
            end else begin
              state_d = S_SQR;
              y_d     = mm.mm_z;
            end
          end
        end
      end
      S_MUL: begin
        if (op_done) begin
          load = 1'b1;
          dec  = 1'b1;
          x_d  = mm.mm_z;
          if (idx == 7'd1) begin
            state_d = S_POST;
            y_d     = 64'd1;
          end else begin
            state_d = S_SQR;
            y_d     = mm.mm_z;
          end
        end
      end
      S_POST: begin
        if (op_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= 7'd0;
      exp_q    <= 64'd0;
      r2_q     <= 64'd0;
      xb       <= 64'd0;
      acc      <= 64'd0;
      result   <= 64'd0;
      mm.mm_x  <= 64'd0;
      mm.mm_y  <= 64'd0;
      mm.mm_m  <= 64'd0;
      mm.mm_n  <= 32'd0;
    end else begin
      state <= state_d;

      if (state == S_IDLE && start) begin
        exp_q   <= exponent;
        r2_q    <= r2;
        mm.mm_m <= modulus;
        mm.mm_n <= n_bits;
        idx     <= (e_len > 7'd64) ? 7'd64 : e_len;
      end else if (dec) begin
        idx <= idx - 7'd1;
      end

      if (load) begin
        mm.mm_x <= x_d;
        mm.mm_y <= y_d;
      end

      if (load || op_done || !in_op) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // Capture the multiplier output into whichever register the finishing step writes
      if (op_done) begin
        case (state)
          S_PRE_X:                xb     <= mm.mm_z;
          S_PRE_A, S_SQR, S_MUL:  acc    <= mm.mm_z;
          S_POST:                 result <= mm.mm_z;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmm_modexp_ctrl.sv
// tb/tb_mmm_modexp_ctrl.sv - randomized and directed bench for mmm_modexp_ctrl at MM_WAIT 1, 2 and 5
module tb_mmm_modexp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_s = 3'b000;
  logic [63:0] base_i = 64'd0;
  logic [63:0] exp_i = 64'd0;
  logic [6:0]  elen_i = 7'd0;
  logic [63:0] mod_i = 64'd0;
  logic [31:0] nb_i = 32'd0;
  logic [63:0] r2_i = 64'd0;
  logic [2:0]  busy_s;
  logic [2:0]  done_s;
  logic [63:0] res_s [3];
  logic [63:0] ox [3];
  logic [63:0] oy [3];
  logic [63:0] om [3];
  logic [31:0] on [3];

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  mmm_modexp_ctrl_if mif0 ();
  mmm_modexp_ctrl_if mif1 ();
  mmm_modexp_ctrl_if mif2 ();

  // Behavioural Montgomery product X*Y*2^-n mod M
  function automatic logic [63:0] mont(logic [63:0] x, logic [63:0] y, logic [63:0] m, logic [31:0] n);
    logic [129:0] t;
    t = 130'(x) * 130'(y);
    for (int i = 0; i < 64; i++) begin
      if (i < int'(n)) begin
        if (t[0]) t = t + 130'(m);
        t = t >> 1;
      end
    end
    if (t >= 130'(m)) t = t - 130'(m);
    return t[63:0];
  endfunction

  always_comb mif0.mm_z = mont(mif0.mm_x, mif0.mm_y, mif0.mm_m, mif0.mm_n);
  always_comb mif1.mm_z = mont(mif1.mm_x, mif1.mm_y, mif1.mm_m, mif1.mm_n);
  always_comb mif2.mm_z = mont(mif2.mm_x, mif2.mm_y, mif2.mm_m, mif2.mm_n);

  assign ox[0] = mif0.mm_x;  assign oy[0] = mif0.mm_y;  assign om[0] = mif0.mm_m;  assign on[0] = mif0.mm_n;
  assign ox[1] = mif1.mm_x;  assign oy[1] = mif1.mm_y;  assign om[1] = mif1.mm_m;  assign on[1] = mif1.mm_n;
  assign ox[2] = mif2.mm_x;  assign oy[2] = mif2.mm_y;  assign om[2] = mif2.mm_m;  assign on[2] = mif2.mm_n;

  mmm_modexp_ctrl #(.MM_WAIT(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .base(base_i), .exponent(exp_i), .e_len(elen_i),
    .modulus(mod_i), .n_bits(nb_i), .r2(r2_i), .busy(busy_s[0]), .done(done_s[0]), .result(res_s[0]),
    .mm(mif0.master)
  );
  mmm_modexp_ctrl #(.MM_WAIT(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .base(base_i), .exponent(exp_i), .e_len(elen_i),
    .modulus(mod_i), .n_bits(nb_i), .r2(r2_i), .busy(busy_s[1]), .done(done_s[1]), .result(res_s[1]),
    .mm(mif1.master)
  );
  mmm_modexp_ctrl #(.MM_WAIT(5)) u_w5 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .base(base_i), .exponent(exp_i), .e_len(elen_i),
    .modulus(mod_i), .n_bits(nb_i), .r2(r2_i), .busy(busy_s[2]), .done(done_s[2]), .result(res_s[2]),
    .mm(mif2.master)
  );

  function automatic int wait_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
  endfunction

  function automatic logic [63:0] modpow(logic [63:0] b, logic [63:0] e, int len, logic [63:0] m);
    logic [127:0] r;
    r = 128'd1;
    for (int i = len - 1; i >= 0; i--) begin
      r = (r * r) % 128'(m);
      if (e[i]) r = (r * 128'(b)) % 128'(m);
    end
    return r[63:0];
  endfunction

  function automatic int ops_of(logic [63:0] e, int len);
    logic [63:0] mask;
    mask = (len >= 64) ? {64{1'b1}} : ((64'd1 << len) - 64'd1);
    return 3 + len + $countones(e & mask);
  endfunction

  function automatic logic [63:0] r2_of(logic [63:0] m, int n);
    logic [127:0] p;
    p = 128'd1 << (2 * n);
    return 64'(p % 128'(m));
  endfunction

  // Entered at a negedge; leaves at the negedge of the cycle after done with start low
  task automatic run_op(input int k, input logic [63:0] b, input logic [63:0] e, input logic [6:0] el,
                        input logic [63:0] m, input logic [31:0] nb, input logic [63:0] rr,
                        input bit garbage, input bit use_want, input logic [63:0] want, input string name);
    int w, len, exp_cyc, cyc;
    bit got, busy_ok, stab_ok, mod_ok;
    logic [63:0] exp_res, px, py;
    w       = wait_of(k);
    len     = (el > 7'd64) ? 64 : int'(el);
    exp_cyc = ops_of(e, len) * (w + 1) + 1;
    exp_res = use_want ? want : modpow(b, e, len, m);
    base_i = b; exp_i = e; elen_i = el; mod_i = m; nb_i = nb; r2_i = rr;
    start_s[k] = 1'b1;
    @(negedge clk);
    if (!garbage) start_s[k] = 1'b0;
    cyc = 1; got = 0; busy_ok = 1; stab_ok = 1; mod_ok = 1;
    px = ox[k]; py = oy[k];
    while (cyc <= exp_cyc + 20) begin
      if (busy_s[k] !== 1'b1) busy_ok = 0;
      if (om[k] !== m || on[k] !== nb) mod_ok = 0;
      if (cyc > 1 && ((cyc - 1) % (w + 1)) != 0 && (ox[k] !== px || oy[k] !== py)) stab_ok = 0;
      px = ox[k]; py = oy[k];
      if (done_s[k] === 1'b1) begin
        got = 1;
        break;
      end
      if (garbage) begin
        base_i = {$urandom, $urandom}; exp_i = {$urandom, $urandom}; elen_i = 7'($urandom);
        mod_i = {$urandom, $urandom}; nb_i = $urandom; r2_i = {$urandom, $urandom};
      end
      @(negedge clk);
      cyc++;
    end
    vec++; if (!got) begin err++; $display("FAIL %s done_seen got=0 expected=1", name); end
    vec++; if (cyc != exp_cyc) begin err++; $display("FAIL %s done_cycle got=%0d expected=%0d", name, cyc, exp_cyc); end
    vec++; if (res_s[k] !== exp_res) begin err++; $display("FAIL %s result got=%0d expected=%0d", name, res_s[k], exp_res); end
    vec++; if (!busy_ok) begin err++; $display("FAIL %s busy_hold got=low expected=high", name); end
    vec++; if (!stab_ok) begin err++; $display("FAIL %s operand_stable got=changed expected=stable", name); end
    vec++; if (!mod_ok) begin err++; $display("FAIL %s mm_m_mm_n got=%0d/%0d expected=%0d/%0d", name, om[k], on[k], m, nb); end
    @(negedge clk);
    start_s[k] = 1'b0;
    vec++; if (done_s[k] !== 1'b0) begin err++; $display("FAIL %s done_single got=%b expected=0", name, done_s[k]); end
    vec++; if (busy_s[k] !== 1'b0) begin err++; $display("FAIL %s busy_fall got=%b expected=0", name, busy_s[k]); end
    vec++; if (res_s[k] !== exp_res) begin err++; $display("FAIL %s result_held got=%0d expected=%0d", name, res_s[k], exp_res); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vec++;
      if ({busy_s[k], done_s[k], res_s[k], ox[k], oy[k], om[k], on[k]} !== '0) begin
        err++;
        $display("FAIL reset_state dut=%0d got busy=%b done=%b result=%0d x=%0d y=%0d m=%0d n=%0d expected all 0",
                 k, busy_s[k], done_s[k], res_s[k], ox[k], oy[k], om[k], on[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small();
    run_op(1, 64'd2, 64'd5, 7'd3, 64'd13, 32'd4, 64'd9, 1'b0, 1'b1, 64'd6, "m13_e5");
    run_op(1, 64'd2, 64'hFF, 7'd0, 64'd13, 32'd4, 64'd9, 1'b0, 1'b1, 64'd1, "m13_elen0");
  endtask

  task automatic test_waits();
    run_op(1, 64'd65, 64'd17, 7'd5, 64'd3233, 32'd12, 64'd1179, 1'b0, 1'b1, 64'd2790, "rsa_w2");
    run_op(0, 64'd65, 64'd17, 7'd5, 64'd3233, 32'd12, 64'd1179, 1'b0, 1'b1, 64'd2790, "rsa_w1");
    run_op(2, 64'd65, 64'd17, 7'd5, 64'd3233, 32'd12, 64'd1179, 1'b0, 1'b1, 64'd2790, "rsa_w5");
  endtask

  task automatic test_start_storm();
    run_op(1, 64'd65, 64'd17, 7'd5, 64'd3233, 32'd12, 64'd1179, 1'b1, 1'b1, 64'd2790, "start_storm");
  endtask

  task automatic test_back_to_back();
    run_op(2, 64'd65, 64'd17, 7'd5, 64'd3233, 32'd12, 64'd1179, 1'b0, 1'b1, 64'd2790, "b2b_first");
    run_op(2, 64'd2790, 64'd2753, 7'd12, 64'd3233, 32'd12, 64'd1179, 1'b0, 1'b1, 64'd65, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int dones;
    base_i = 64'd65; exp_i = 64'd17; elen_i = 7'd5; mod_i = 64'd3233; nb_i = 32'd12; r2_i = 64'd1179;
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if ({busy_s[1], done_s[1], res_s[1], ox[1], oy[1], om[1], on[1]} !== '0) begin
      err++;
      $display("FAIL async_reset got busy=%b done=%b result=%0d x=%0d y=%0d m=%0d n=%0d expected all 0",
               busy_s[1], done_s[1], res_s[1], ox[1], oy[1], om[1], on[1]);
    end
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_s[1] === 1'b1) dones++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done_s[1] === 1'b1) dones++;
    end
    vec++; if (dones != 0) begin err++; $display("FAIL reset_no_done got=%0d pulses expected=0", dones); end
    run_op(1, 64'd2790, 64'd2753, 7'd12, 64'd3233, 32'd12, 64'd1179, 1'b0, 1'b1, 64'd65, "after_reset_decrypt");
  endtask

  task automatic test_clamp();
    run_op(1, 64'd65, 64'd17, 7'd100, 64'd3233, 32'd12, 64'd1179, 1'b0, 1'b1, 64'd2790, "elen_clamp");
  endtask

  task automatic test_random();
    logic [63:0] m, b, e;
    logic [31:0] nb;
    logic [6:0]  el;
    int k;
    for (int it = 0; it < 10; it++) begin
      m  = 64'($urandom_range(32'h7FFF_FFFF, 32'd3)) | 64'd1;
      nb = $urandom_range(48, 31);
      b  = {$urandom, $urandom} % m;
      e  = {$urandom, $urandom};
      el = 7'($urandom_range(80, 0));
      k  = $urandom_range(2, 0);
      run_op(k, b, e, el, m, nb, r2_of(m, int'(nb)), it[0], 1'b0, 64'd0, $sformatf("random_%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_waits();
    test_start_storm();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/mmm_modexp_ctrl.md
# mmm_modexp_ctrl

Sequencing controller for RSA modular exponentiation, result = base^exponent mod M. It sits directly upstream of the combinational Montgomery multiplier `mmm`. It drives that multiplier's X/Y/M/m operands, waits a fixed settle time, and captures Z. Using left-to-right square-and-multiply in the Montgomery domain, it chains the pre-conversion, square, multiply and post-conversion operations to produce an ordinary-domain result.

## Interface
- MM_WAIT, default 2: cycles operands are held before mm_z is sampled (≥1). It must cover the multiplier's settle time.
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only in IDLE
- base  input  64  message, must be < modulus
- exponent  input  64  exponent; bits ≥ e_len ignored
- e_len  input  7  exponent bit count, 0..64; values >64 clamp to 64
- modulus  input  64  odd M, M > 1
- n_bits  input  32  Montgomery width m, R = 2^n_bits, M < R
- r2  input  64  precomputed R^2 mod M
- busy  output  1  high from accept until done cycle inclusive
- done  output  1  one-cycle pulse, result valid
- result  output  64  exponentiation result, held until next accept
- mm_x, mm_y  output  64  multiplier operands (registered)
- mm_m  output  64  modulus to multiplier (registered)
- mm_n  output  32  width m to multiplier (registered)
- mm_z  input  64  multiplier result, sampled after MM_WAIT cycles

## Operation
- On accept, latch all inputs into internal registers. Later input changes have no effect until the next accept. mm_m and mm_n are loaded from the latched values.
- State machine: IDLE → PRE_X → PRE_A → (SQR → [MUL]) × e_len → POST → DONE → IDLE.
- PRE_X: xb = MM(base, r2).
- PRE_A: a = MM(1, r2), i.e. R mod M.
- SQR: a = MM(a, a).
- MUL: a = MM(a, xb). This state is entered only if the current exponent bit is 1.
- Exponent bits are scanned from bit e_len−1 down to bit 0. A 7-bit index register is decremented after each SQR/MUL pair.
- If e_len = 0, go PRE_A → POST directly.
- POST: result = MM(a, 1). DONE asserts done, then returns to IDLE.
- Each MM operation:
  - On the state-entry edge, mm_x and mm_y are registered and the wait counter is cleared.
  - The counter increments each cycle.
  - When the counter = MM_WAIT, mm_z is captured into the destination register and the machine advances.
  - Each operation occupies MM_WAIT+1 cycles.
- Arithmetic: the block does no reduction itself. All values are 64-bit and zero-extended. The constant 1 is 64'd1.
- start while busy: ignored, with no effect on the current operation.
- start in the DONE cycle: ignored. It is accepted only from IDLE on a later cycle.

## Timing
- Reset (asynchronous assert, synchronous deassert expected) forces:
  - state IDLE, busy 0, done 0, result 0, mm_x 0, mm_y 0, mm_m 0, mm_n 0
  - all internal registers 0
- Reset mid-operation aborts the current operation with no done pulse.
- Accept edge: start=1 in IDLE at edge T0. busy goes high after T0, and operands for PRE_X appear after T0.
- Operation count: ops = 3 + e_len + popcount(exponent[e_len−1:0]).
- done is high for exactly one cycle, at cycle T0 + ops·(MM_WAIT+1) + 1. result updates on the same edge that raises done.
- busy drops on the edge after the done cycle. The earliest next accept is one cycle after the done cycle.
- mm_x, mm_y, mm_m and mm_n are stable for the full MM_WAIT+1 cycles of each operation.

## Test plan
- M=13, n_bits=4, r2=9, base=2, exponent=5, e_len=3, MM_WAIT=2 (bench uses a behavioural combinational `mmm`):
  - result=6
  - ops=8, so done occurs 25 cycles after accept
  - busy high throughout
- Same M, e_len=0, exponent=0xFF → result=1, ops=3, done at T0+10.
- M=3233, n_bits=12, r2=1179, base=65, exponent=17, e_len=5:
  - result=2790, ops=10
  - repeat with MM_WAIT=1 and MM_WAIT=5: identical result, done at T0+21 and T0+61.
- Pulse start every cycle during the run of the M=3233 case, with new garbage inputs:
  - exactly one done, result=2790
  - the next accept happens only after busy falls.
- Assert rst_n=0 mid-SQR of the M=3233 case:
  - all outputs 0 immediately (asynchronous)
  - no done pulse
  - after release, a fresh start with base=2790, exponent=2753 (d), e_len=12 yields result=65.
- e_len=100 with exponent=17, M=3233 → behaves as e_len=64, result=2790, ops=3+64+2=69.
